// File: rtl/stage4_defast_dict_sched_if.sv
// Handshake/bus bundle for the stage-4 de-fast sequencing controller.
//   master : upstream/downstream environment (drives beats, out_ready, dict_clear)
//   slave  : the scheduler (drives in_ready and the serialised output)
// Signals:
//   in_valid/in_ready/in_mask       beat handshake, bit k-1 of in_mask = lane k populated
//   msg_fast_1..3                   raw fast messages of the beat
//   dict_clear                      zero the copy dictionary (packet boundary)
//   out_valid/out_ready             serialised message handshake
//   out_msg_fast                    message presented to the datapath
//   field_PID1/MC1/MT1              dictionary snapshot paired with out_msg_fast
//   field_EBSN4                     expected sequence number paired with out_msg_fast
//   field_RBSN4                     running reject count
interface stage4_defast_dict_sched_if #(
    parameter int unsigned FAST_W = 328,
    parameter int unsigned FLD_W  = 8,
    parameter int unsigned SEQ_W  = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_mask;
    logic [FAST_W-1:0] msg_fast_1;
    logic [FAST_W-1:0] msg_fast_2;
    logic [FAST_W-1:0] msg_fast_3;
    logic              dict_clear;
    logic              out_valid;
    logic              out_ready;
    logic [FAST_W-1:0] out_msg_fast;
    logic [FLD_W-1:0]  field_PID1;
    logic [FLD_W-1:0]  field_MC1;
    logic [FLD_W-1:0]  field_MT1;
    logic [SEQ_W-1:0]  field_EBSN4;
    logic [SEQ_W-1:0]  field_RBSN4;

    modport master (
        output in_valid, in_mask, msg_fast_1, msg_fast_2, msg_fast_3, dict_clear, out_ready,
        input  in_ready, out_valid, out_msg_fast, field_PID1, field_MC1, field_MT1,
               field_EBSN4, field_RBSN4
    );

    modport slave (
        input  in_valid, in_mask, msg_fast_1, msg_fast_2, msg_fast_3, dict_clear, out_ready,
        output in_ready, out_valid, out_msg_fast, field_PID1, field_MC1, field_MT1,
               field_EBSN4, field_RBSN4
    );
endinterface

// File: rtl/stage4_defast_dict_sched.sv
// Sequencing controller in front of the stage-4 FAST de-fast datapath.
// Accepts a beat of up to three fast messages and serialises them one lane per cycle
// (lane 1, 2, 3). Owns the copy-operator dictionary (PID1/MC1/MT1) and the EBSN4/RBSN4
// counters. Every message is paired with the dictionary state left by its predecessor.
// Ports:
//   clk  : sole clock
//   rst  : synchronous active-high reset
//   bus  : stage4_defast_dict_sched_if slave modport (beat input, serialised output)
module stage4_defast_dict_sched #(
    parameter int unsigned FAST_W   = 328,
    parameter int unsigned PMAP_LSB = 0,
    parameter int unsigned FLD_W    = 8,
    parameter int unsigned SEQ_W    = 32
) (
    input logic                        clk,
    input logic                        rst,
    stage4_defast_dict_sched_if.slave  bus
);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e                  state_q, state_d;
    logic [2:0]              pending_q, pending_d;
    logic [2:0][FAST_W-1:0]  msg_q, msg_d;

    // Copy-operator dictionary
    logic [FLD_W-1:0]        dict_pid_q, dict_pid_d;
    logic [FLD_W-1:0]        dict_mc_q, dict_mc_d;
    logic [FLD_W-1:0]        dict_mt_q, dict_mt_d;

    logic [SEQ_W-1:0]        ebsn_q, ebsn_d;
    logic [SEQ_W-1:0]        rbsn_q, rbsn_d;

    // Output register
    logic                    out_valid_q, out_valid_d;
    logic [FAST_W-1:0]       out_msg_q, out_msg_d;
    logic [FLD_W-1:0]        out_pid_q, out_pid_d;
    logic [FLD_W-1:0]        out_mc_q, out_mc_d;
    logic [FLD_W-1:0]        out_mt_q, out_mt_d;
    logic [SEQ_W-1:0]        out_ebsn_q, out_ebsn_d;

    // Working signals
    logic                    in_ready_c;
    logic                    can_adv;
    logic                    consume;
    logic [2:0]              src_pend;
    logic [2:0][FAST_W-1:0]  src_msg;
    logic [2:0][FAST_W-1:0]  in_msgs;
    logic [2:0]              lane_oh;
    logic [2:0]              rem;
    logic [FAST_W-1:0]       cur_msg;
    logic [15:0]             pm;
    logic                    legal;
    logic                    pid_pres, mc_pres, mt_pres;
    logic [FLD_W-1:0]        byte0, byte1, byte2;
    logic [FLD_W-1:0]        mc_byte, mt_byte;
    logic [FLD_W-1:0]        base_pid, base_mc, base_mt;

    assign in_msgs = {bus.msg_fast_3, bus.msg_fast_2, bus.msg_fast_1};

    // The output register can take a new message when it is empty or being drained.
    assign can_adv = !out_valid_q || bus.out_ready;

    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        msg_d       = msg_q;
        ebsn_d      = ebsn_q;
        rbsn_d      = rbsn_q;
        out_valid_d = out_valid_q;
        out_msg_d   = out_msg_q;
        out_pid_d   = out_pid_q;
        out_mc_d    = out_mc_q;
        out_mt_d    = out_mt_q;
        out_ebsn_d  = out_ebsn_q;
        in_ready_c  = 1'b0;
        src_pend    = '0;
        src_msg     = msg_q;
        lane_oh     = '0;
        cur_msg     = '0;

        // dict_clear acts first so a coinciding load snapshots zeros.
        base_pid = bus.dict_clear ? '0 : dict_pid_q;
        base_mc  = bus.dict_clear ? '0 : dict_mc_q;
        base_mt  = bus.dict_clear ? '0 : dict_mt_q;
        dict_pid_d = base_pid;
        dict_mc_d  = base_mc;
        dict_mt_d  = base_mt;

        // In IDLE a beat is processed in its handshake cycle so its first lane
        // appears one cycle later; in RUN the latched beat is used.
        if (state_q == StIdle) begin
            in_ready_c = 1'b1;
            if (bus.in_valid) begin
                src_pend = bus.in_mask;
                src_msg  = in_msgs;
                msg_d    = in_msgs;
            end
        end else begin
            src_pend = pending_q;
            src_msg  = msg_q;
        end

        // Lowest pending lane first
        if (src_pend[0]) begin
            lane_oh = 3'b001;
            cur_msg = src_msg[0];
        end else if (src_pend[1]) begin
            lane_oh = 3'b010;
            cur_msg = src_msg[1];
        end else if (src_pend[2]) begin
            lane_oh = 3'b100;
            cur_msg = src_msg[2];
        end

        pm       = cur_msg[PMAP_LSB +: 16];
        legal    = pm[15] && (pm[11:0] == 12'h000);
        // Presence bit 0 means the field is carried in the message.
        pid_pres = !pm[14];
        mc_pres  = !pm[13];
        mt_pres  = !pm[12];

        // Present fields are packed from the top byte downward.
        byte0   = cur_msg[FAST_W-1 -: FLD_W];
        byte1   = cur_msg[FAST_W-1-FLD_W -: FLD_W];
        byte2   = cur_msg[FAST_W-1-2*FLD_W -: FLD_W];
        mc_byte = pid_pres ? byte1 : byte0;
        case ({pid_pres, mc_pres})
            2'b11:   mt_byte = byte2;
            2'b10,
            2'b01:   mt_byte = byte1;
            default: mt_byte = byte0;
        endcase

        consume = can_adv && (src_pend != 3'b000);
        rem     = consume ? (src_pend & ~lane_oh) : src_pend;

        // Register drains on out_ready unless refilled below.
        if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end

        if (consume) begin
            if (legal) begin
                out_valid_d = 1'b1;
                out_msg_d   = cur_msg;
                out_pid_d   = base_pid;
                out_mc_d    = base_mc;
                out_mt_d    = base_mt;
                out_ebsn_d  = ebsn_q;
                ebsn_d      = ebsn_q + SEQ_W'(1);
                if (pid_pres) dict_pid_d = byte0;
                if (mc_pres)  dict_mc_d  = mc_byte;
                if (mt_pres)  dict_mt_d  = mt_byte;
            end else begin
                rbsn_d = rbsn_q + SEQ_W'(1);
            end
        end

        if (state_q == StIdle) begin
            if (bus.in_valid) begin
                pending_d = rem;
                state_d   = (rem != 3'b000) ? StRun : StIdle;
            end
        end else begin
            pending_d = rem;
            // Last lane consumed this cycle: accept the next beat without a bubble.
            if (consume && rem == 3'b000) begin
                in_ready_c = 1'b1;
                if (bus.in_valid) begin
                    msg_d     = in_msgs;
                    pending_d = bus.in_mask;
                    state_d   = (bus.in_mask != 3'b000) ? StRun : StIdle;
                end else begin
                    state_d = StIdle;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            pending_q   <= '0;
            msg_q       <= '0;
            dict_pid_q  <= '0;
            dict_mc_q   <= '0;
            dict_mt_q   <= '0;
            ebsn_q      <= '0;
            rbsn_q      <= '0;
            out_valid_q <= 1'b0;
            out_msg_q   <= '0;
            out_pid_q   <= '0;
            out_mc_q    <= '0;
            out_mt_q    <= '0;
            out_ebsn_q  <= '0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            msg_q       <= msg_d;
            dict_pid_q  <= dict_pid_d;
            dict_mc_q   <= dict_mc_d;
            dict_mt_q   <= dict_mt_d;
            ebsn_q      <= ebsn_d;
            rbsn_q      <= rbsn_d;
            out_valid_q <= out_valid_d;
            out_msg_q   <= out_msg_d;
            out_pid_q   <= out_pid_d;
            out_mc_q    <= out_mc_d;
            out_mt_q    <= out_mt_d;
            out_ebsn_q  <= out_ebsn_d;
        end
    end

    assign bus.in_ready     = in_ready_c && !rst;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_msg_fast = out_msg_q;
    assign bus.field_PID1   = out_pid_q;
    assign bus.field_MC1    = out_mc_q;
    assign bus.field_MT1    = out_mt_q;
    assign bus.field_EBSN4  = out_ebsn_q;
    assign bus.field_RBSN4  = rbsn_q;

endmodule

// File: tb/tb_stage4_defast_dict_sched.sv
// Self-checking bench for stage4_defast_dict_sched: directed scenarios followed by
// randomized beats, all checked against a message-level reference model.
module tb_stage4_defast_dict_sched;

    localparam int unsigned FAST_W = 328;
    localparam int unsigned FLD_W  = 8;
    localparam int unsigned SEQ_W  = 32;

    typedef struct packed {
        logic [FAST_W-1:0] msg;
        logic [7:0]        pid;
        logic [7:0]        mc;
        logic [7:0]        mt;
        logic [31:0]       ebsn;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    stage4_defast_dict_sched_if #(.FAST_W(FAST_W), .FLD_W(FLD_W), .SEQ_W(SEQ_W)) bus ();

    stage4_defast_dict_sched #(
        .FAST_W  (FAST_W),
        .PMAP_LSB(0),
        .FLD_W   (FLD_W),
        .SEQ_W   (SEQ_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    bit          rnd_ready = 0;
    exp_t        exp_q[$];
    int          hs_cyc[$];
    logic [7:0]  md[3];
    int unsigned m_ebsn, m_rbsn;

    task automatic chk(input string tag, input logic [FAST_W-1:0] obs,
                       input logic [FAST_W-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        md = '{default: 8'h00};
        m_ebsn = 0;
        m_rbsn = 0;
        exp_q.delete();
        hs_cyc.delete();
    endtask

    // One message through the copy-dictionary rules.
    task automatic model_lane(input logic [FAST_W-1:0] m, input bit clr);
        logic [15:0] pm;
        exp_t        e;
        int          k;
        pm = m[15:0];
        if (clr) md = '{default: 8'h00};
        if (pm[15] !== 1'b1 || pm[11:0] !== 12'h000) begin
            m_rbsn++;
            return;
        end
        e.msg  = m;
        e.pid  = md[0];
        e.mc   = md[1];
        e.mt   = md[2];
        e.ebsn = m_ebsn;
        exp_q.push_back(e);
        m_ebsn++;
        k = 0;
        for (int f = 0; f < 3; f++) begin
            if (pm[14-f] == 1'b0) begin
                md[f] = m[FAST_W-1-8*k -: 8];
                k++;
            end
        end
    endtask

    function automatic logic [FAST_W-1:0] mk_msg(input logic [15:0] pm, input logic [7:0] b0,
                                                 input logic [7:0] b1, input logic [7:0] b2);
        logic [FAST_W-1:0] m;
        for (int i = 0; i < FAST_W; i++) m[i] = 1'($urandom_range(0, 1));
        m[FAST_W-1 -: 8]  = b0;
        m[FAST_W-9 -: 8]  = b1;
        m[FAST_W-17 -: 8] = b2;
        m[15:0]           = pm;
        return m;
    endfunction

    function automatic logic [15:0] rnd_pm();
        logic [15:0] pm;
        pm = {1'b1, 3'($urandom_range(0, 7)), 12'h000};
        if ($urandom_range(0, 4) == 0) begin
            if ($urandom_range(0, 1) == 0) pm[15] = 1'b0;
            else pm[$urandom_range(0, 11)] = 1'b1;
        end
        return pm;
    endfunction

    // Output-side scoreboard for the coming edge, then advance one cycle.
    task automatic tick();
        exp_t e;
        if (!rst && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            hs_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                chk("spurious_out_valid", bus.out_valid, 0);
            end else begin
                e = exp_q.pop_front();
                chk("out_msg_fast", bus.out_msg_fast, e.msg);
                chk("field_PID1", bus.field_PID1, e.pid);
                chk("field_MC1", bus.field_MC1, e.mc);
                chk("field_MT1", bus.field_MT1, e.mt);
                chk("field_EBSN4", bus.field_EBSN4, e.ebsn);
            end
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
        if (rnd_ready) bus.out_ready = 1'($urandom_range(0, 1));
        #1;
    endtask

    task automatic do_reset();
        bus.in_valid   = 1'b0;
        bus.dict_clear = 1'b0;
        rst = 1'b1;
        tick();
        chk("in_ready_during_reset", bus.in_ready, 0);
        tick();
        rst = 1'b0;
        #1;
        model_reset();
        chk("in_ready_after_reset", bus.in_ready, 1);
    endtask

    // Present a beat until accepted (bounded); returns the handshake cycle.
    task automatic send_beat(input logic [2:0] mask, input logic [FAST_W-1:0] a,
                             input logic [FAST_W-1:0] b, input logic [FAST_W-1:0] c,
                             input int clr_lane, output int hcyc);
        int n = 0;
        bus.in_valid   = 1'b1;
        bus.in_mask    = mask;
        bus.msg_fast_1 = a;
        bus.msg_fast_2 = b;
        bus.msg_fast_3 = c;
        #1;
        while (bus.in_ready !== 1'b1 && n < 60) begin
            tick();
            n++;
        end
        chk("in_ready_handshake", bus.in_ready, 1);
        hcyc = cyc;
        if (mask[0]) model_lane(a, clr_lane == 1);
        if (mask[1]) model_lane(b, clr_lane == 2);
        if (mask[2]) model_lane(c, clr_lane == 3);
        tick();
        bus.in_valid = 1'b0;
        #1;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() > 0 && n < 300) begin
            tick();
            n++;
        end
        chk("drain_remaining", exp_q.size(), 0);
        tick();
        tick();
    endtask

    task automatic chk_spacing(input string tag, input int n, input int gap);
        chk({tag, "_count"}, hs_cyc.size(), n);
        for (int i = 1; i < hs_cyc.size(); i++) chk({tag, "_spacing"}, hs_cyc[i] - hs_cyc[i-1], gap);
    endtask

    initial begin
        logic [FAST_W-1:0] m1, m2, m3;
        int hc, hc2;

        rst            = 1'b1;
        bus.in_valid   = 1'b0;
        bus.in_mask    = '0;
        bus.msg_fast_1 = '0;
        bus.msg_fast_2 = '0;
        bus.msg_fast_3 = '0;
        bus.dict_clear = 1'b0;
        bus.out_ready  = 1'b1;

        // Reset state
        do_reset();
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_msg", bus.out_msg_fast, 0);
        chk("rst_pid", bus.field_PID1, 0);
        chk("rst_mc", bus.field_MC1, 0);
        chk("rst_mt", bus.field_MT1, 0);
        chk("rst_ebsn", bus.field_EBSN4, 0);
        chk("rst_rbsn", bus.field_RBSN4, 0);

        // Full legal beat, then a copy-all lane exposes the final dictionary 44/22/55
        m1 = mk_msg(16'h8000, 8'h11, 8'h22, 8'h33);
        m2 = mk_msg(16'hF000, 8'hA5, 8'h5A, 8'hC3);
        m3 = mk_msg(16'hA000, 8'h44, 8'h55, 8'h77);
        send_beat(3'b111, m1, m2, m3, 0, hc);
        drain();
        chk_spacing("beat111", 3, 1);
        chk("beat111_latency", hs_cyc[0] - hc, 1);
        hs_cyc.delete();
        send_beat(3'b001, mk_msg(16'hF000, 8'h01, 8'h02, 8'h03), m2, m3, 0, hc);
        drain();
        chk("final_dict_rbsn", bus.field_RBSN4, 0);

        // Illegal lane 2
        do_reset();
        m2 = mk_msg(16'h8001, 8'h99, 8'h98, 8'h97);
        send_beat(3'b111, m1, m2, m3, 0, hc);
        drain();
        chk_spacing("illegal", 2, 2);
        chk("illegal_rbsn", bus.field_RBSN4, m_rbsn);
        chk("illegal_ebsn_last", bus.field_EBSN4, m_ebsn - 1);

        // Output stall for four cycles after the first load
        do_reset();
        bus.out_ready = 1'b0;
        m2 = mk_msg(16'hF000, 8'h00, 8'h00, 8'h00);
        send_beat(3'b111, m1, m2, m3, 0, hc);
        for (int i = 0; i < 4; i++) begin
            chk("stall_valid", bus.out_valid, 1);
            chk("stall_msg", bus.out_msg_fast, exp_q[0].msg);
            chk("stall_pid", bus.field_PID1, exp_q[0].pid);
            chk("stall_ebsn", bus.field_EBSN4, exp_q[0].ebsn);
            chk("stall_in_ready", bus.in_ready, 0);
            tick();
        end
        bus.out_ready = 1'b1;
        #1;
        drain();
        chk_spacing("stall_resume", 3, 1);

        // Back-to-back beats 101 then 010
        do_reset();
        send_beat(3'b101, m1, m2, m3, 0, hc);
        send_beat(3'b010, m1, mk_msg(16'h9000, 8'h0F, 8'h1E, 8'h2D), m3, 0, hc2);
        chk("b2b_in_ready_cycle", hc2 - hc, 1);
        drain();
        chk_spacing("b2b", 3, 1);

        // dict_clear coinciding with the lane 2 load
        do_reset();
        m2 = mk_msg(16'hB000, 8'h66, 8'hEE, 8'hDD);
        m3 = mk_msg(16'hF000, 8'h12, 8'h34, 8'h56);
        send_beat(3'b111, m1, m2, m3, 2, hc);
        bus.dict_clear = 1'b1;
        tick();
        bus.dict_clear = 1'b0;
        #1;
        drain();
        chk_spacing("dict_clear", 3, 1);

        // Reset mid-beat with the output stalled
        do_reset();
        bus.out_ready = 1'b0;
        send_beat(3'b111, m1, m1, m1, 0, hc);
        rst = 1'b1;
        tick();
        chk("midrst_in_ready", bus.in_ready, 0);
        chk("midrst_out_valid", bus.out_valid, 0);
        chk("midrst_out_msg", bus.out_msg_fast, 0);
        chk("midrst_ebsn", bus.field_EBSN4, 0);
        chk("midrst_rbsn", bus.field_RBSN4, 0);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        model_reset();
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("midrst_no_emit", bus.out_valid, 0);
            tick();
        end
        send_beat(3'b001, mk_msg(16'hF000, 8'h77, 8'h77, 8'h77), m1, m1, 0, hc);
        drain();

        // Randomized beats with random back-pressure
        do_reset();
        rnd_ready = 1;
        for (int b = 0; b < 60; b++) begin
            m1 = mk_msg(rnd_pm(), 8'($urandom), 8'($urandom), 8'($urandom));
            m2 = mk_msg(rnd_pm(), 8'($urandom), 8'($urandom), 8'($urandom));
            m3 = mk_msg(rnd_pm(), 8'($urandom), 8'($urandom), 8'($urandom));
            send_beat(3'($urandom_range(0, 7)), m1, m2, m3, 0, hc);
            if ($urandom_range(0, 3) == 0) tick();
        end
        rnd_ready = 0;
        bus.out_ready = 1'b1;
        #1;
        drain();
        chk("rand_rbsn", bus.field_RBSN4, m_rbsn);
        chk("rand_idle_out_valid", bus.out_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
